// File: rtl/counter_cmd_if.sv
// Request/command bundle between a requester and counter_cmd_gen.
// The master side issues requests, the slave side drives commands and status.
interface counter_cmd_if;
  logic       up_req;
  logic [3:0] up_amt;
  logic       dn_req;
  logic [3:0] dn_amt;
  logic       load_req;
  logic [3:0] load_value;
  logic [3:0] counter_value;

  logic       reinit;
  logic [3:0] initial_value;
  logic       incr_valid;
  logic [1:0] incr;
  logic       decr_valid;
  logic [1:0] decr;
  logic [5:0] pend_up;
  logic [5:0] pend_dn;
  logic       busy;
  logic       overflow;
  logic [3:0] mirror;
  logic       mismatch;

  modport master (
    output up_req, up_amt, dn_req, dn_amt, load_req, load_value, counter_value,
    input  reinit, initial_value, incr_valid, incr, decr_valid, decr,
           pend_up, pend_dn, busy, overflow, mirror, mismatch
  );

  modport slave (
    input  up_req, up_amt, dn_req, dn_amt, load_req, load_value, counter_value,
    output reinit, initial_value, incr_valid, incr, decr_valid, decr,
           pend_up, pend_dn, busy, overflow, mirror, mismatch
  );
endinterface

// File: rtl/counter_cmd_gen.sv
// Accumulates up/down requests and drains them as 1..3 step counter commands.
// Define COUNTER_CMD_CHECK_EN to build the expected-value mirror and mismatch checker.
module counter_cmd_gen (
  input  logic         clk,
  input  logic         rst_n,
  counter_cmd_if.slave cmd_if
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, LOAD = 2'd2} state_e;

  state_e     state_q, state_d;
  logic [5:0] pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
  logic       reinit_q, reinit_d;
  logic [3:0] init_q, init_d;
  logic       incr_valid_q, incr_valid_d, decr_valid_q, decr_valid_d;
  logic [1:0] incr_q, incr_d, decr_q, decr_d;
  logic       overflow_q, overflow_d;
  logic       busy;

  logic [1:0] issue_up, issue_dn;
  logic [6:0] add_up, add_dn, sum_up, sum_dn;

  // Datapath next state; the 7-bit sums hold the unsaturated value so overflow is visible.
  always_comb begin
    // NOTE: every signal gets a default up front so no branch can leave one unassigned (no latches).
    issue_up     = (pend_up_q > 6'd3) ? 2'd3 : pend_up_q[1:0];
    issue_dn     = (pend_dn_q > 6'd3) ? 2'd3 : pend_dn_q[1:0];
    add_up       = cmd_if.up_req ? {3'b000, cmd_if.up_amt} : 7'd0;
    add_dn       = cmd_if.dn_req ? {3'b000, cmd_if.dn_amt} : 7'd0;
    sum_up       = {1'b0, pend_up_q} - {5'd0, issue_up} + add_up;
    sum_dn       = {1'b0, pend_dn_q} - {5'd0, issue_dn} + add_dn;
    reinit_d     = 1'b0;
    init_d       = init_q;
    incr_d       = issue_up;
    decr_d       = issue_dn;
    if (cmd_if.load_req) begin
      sum_up   = add_up;
      sum_dn   = add_dn;
      reinit_d = 1'b1;
      init_d   = cmd_if.load_value;
      incr_d   = 2'd0;
      decr_d   = 2'd0;
    end
    incr_valid_d = (incr_d != 2'd0);
    decr_valid_d = (decr_d != 2'd0);
    pend_up_d    = (sum_up > 7'd63) ? 6'd63 : sum_up[5:0];
    pend_dn_d    = (sum_dn > 7'd63) ? 6'd63 : sum_dn[5:0];
    overflow_d   = overflow_q | (sum_up > 7'd63) | (sum_dn > 7'd63);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_up_q    <= '0;
      pend_dn_q    <= '0;
      reinit_q     <= 1'b0;
      init_q       <= '0;
      incr_valid_q <= 1'b0;
      incr_q       <= '0;
      decr_valid_q <= 1'b0;
      decr_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      pend_up_q    <= pend_up_d;
      pend_dn_q    <= pend_dn_d;
      reinit_q     <= reinit_d;
      init_q       <= init_d;
      incr_valid_q <= incr_valid_d;
      incr_q       <= incr_d;
      decr_valid_q <= decr_valid_d;
      decr_q       <= decr_d;
      overflow_q   <= overflow_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state; LOAD wins, otherwise stay busy while work remains.
  always_comb begin
    state_d = IDLE;
    if (cmd_if.load_req)
      state_d = LOAD;
    else if ((pend_up_d != 6'd0) || (pend_dn_d != 6'd0) || incr_valid_d || decr_valid_d)
      state_d = ISSUE;
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  assign cmd_if.reinit        = reinit_q;
  assign cmd_if.initial_value = init_q;
  assign cmd_if.incr_valid    = incr_valid_q;
  assign cmd_if.incr          = incr_q;
  assign cmd_if.decr_valid    = decr_valid_q;
  assign cmd_if.decr          = decr_q;
  assign cmd_if.pend_up       = pend_up_q;
  assign cmd_if.pend_dn       = pend_dn_q;
  assign cmd_if.busy          = busy;
  assign cmd_if.overflow      = overflow_q;

`ifdef COUNTER_CMD_CHECK_EN
  logic [3:0] mirror_q;
  logic       armed_q, mismatch_q;

  // The mirror tracks the counter one edge behind the commands, so comparison starts
  // only once a reinit has already been folded into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mirror_q   <= '0;
      armed_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      if (reinit_q)
        mirror_q <= init_q;
      else
        mirror_q <= mirror_q + (incr_valid_q ? {2'b00, incr_q} : 4'd0)
                             - (decr_valid_q ? {2'b00, decr_q} : 4'd0);
      armed_q <= armed_q | reinit_q;
      if (armed_q && (cmd_if.counter_value != mirror_q))
        mismatch_q <= 1'b1;
    end
  end

  assign cmd_if.mirror   = mirror_q;
  assign cmd_if.mismatch = mismatch_q;
`else
  assign cmd_if.mirror   = '0;
  assign cmd_if.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_counter_cmd_gen.sv
// Scoreboard bench for counter_cmd_gen: a driver pushes model predictions, a monitor
// pops and compares one prediction per clock edge.
module tb_counter_cmd_gen;

`ifdef COUNTER_CMD_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  counter_cmd_if bus ();

  counter_cmd_gen dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int reinit; int init; int iv; int inc; int dv; int dec;
    int pu; int pd; int busy; int ov; int mirror; int mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: pending totals as plain integers, commands as issued amounts.
  int m_pu, m_pd, m_inc, m_dec, m_reinit, m_init, m_ov, m_mirror, m_armed, m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_pu = 0; m_pd = 0; m_inc = 0; m_dec = 0; m_reinit = 0; m_init = 0;
    m_ov = 0; m_mirror = 0; m_armed = 0; m_mis = 0;
  endtask

  task automatic model_step(input bit ur, input int ua, input bit dr, input int da,
                            input bit lr, input int lv, input int cv);
    exp_t e;
    int   raw_u, raw_d, iu, idn;
    // Counter-side view uses the commands visible before this edge.
    if (m_armed != 0 && cv != m_mirror) m_mis = 1;
    if (m_reinit != 0) m_armed = 1;
    m_mirror = (m_reinit != 0) ? m_init : (m_mirror + m_inc - m_dec + 16) % 16;
    if (lr) begin
      raw_u = ur ? ua : 0;
      raw_d = dr ? da : 0;
      m_inc = 0; m_dec = 0; m_reinit = 1; m_init = lv;
    end else begin
      iu  = (m_pu < 3) ? m_pu : 3;
      idn = (m_pd < 3) ? m_pd : 3;
      raw_u = m_pu - iu + (ur ? ua : 0);
      raw_d = m_pd - idn + (dr ? da : 0);
      m_inc = iu; m_dec = idn; m_reinit = 0;
    end
    if (raw_u > 63) begin m_ov = 1; raw_u = 63; end
    if (raw_d > 63) begin m_ov = 1; raw_d = 63; end
    m_pu = raw_u;
    m_pd = raw_d;
    e.reinit = m_reinit;  e.init = m_init;
    e.iv     = (m_inc != 0) ? 1 : 0;  e.inc = m_inc;
    e.dv     = (m_dec != 0) ? 1 : 0;  e.dec = m_dec;
    e.pu     = m_pu;  e.pd = m_pd;
    e.busy   = (m_reinit != 0 || m_pu != 0 || m_pd != 0 || m_inc != 0 || m_dec != 0) ? 1 : 0;
    e.ov     = m_ov;
    e.mirror = CHECK_EN ? m_mirror : 0;
    e.mis    = CHECK_EN ? m_mis : 0;
    exp_q.push_back(e);
  endtask

  // cv_mode: -1 follows the ideal counter, -2 corrupts it, >=0 forces that value.
  task automatic cycle(input bit ur, input int ua, input bit dr, input int da,
                       input bit lr, input int lv, input int cv_mode);
    int cv;
    @(negedge clk);
    if (cv_mode >= 0)       cv = cv_mode;
    else if (cv_mode == -2) cv = (m_mirror + 1) % 16;
    else                    cv = m_mirror;
    bus.up_req        = ur;
    bus.up_amt        = 4'(ua);
    bus.dn_req        = dr;
    bus.dn_amt        = 4'(da);
    bus.load_req      = lr;
    bus.load_value    = 4'(lv);
    bus.counter_value = 4'(cv);
    model_step(ur, ua, dr, da, lr, lv, cv);
  endtask

  task automatic idle();
    cycle(1'b0, 0, 1'b0, 0, 1'b0, 0, -1);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_reinit"},   32'(bus.reinit),        0);
    check({tag, "_init"},     32'(bus.initial_value), 0);
    check({tag, "_incr_v"},   32'(bus.incr_valid),    0);
    check({tag, "_incr"},     32'(bus.incr),          0);
    check({tag, "_decr_v"},   32'(bus.decr_valid),    0);
    check({tag, "_decr"},     32'(bus.decr),          0);
    check({tag, "_pend_up"},  32'(bus.pend_up),       0);
    check({tag, "_pend_dn"},  32'(bus.pend_dn),       0);
    check({tag, "_busy"},     32'(bus.busy),          0);
    check({tag, "_overflow"}, 32'(bus.overflow),      0);
    check({tag, "_mirror"},   32'(bus.mirror),        0);
    check({tag, "_mismatch"}, 32'(bus.mismatch),      0);
  endtask

  task automatic clear_inputs();
    bus.up_req = 1'b0; bus.up_amt = '0; bus.dn_req = 1'b0; bus.dn_amt = '0;
    bus.load_req = 1'b0; bus.load_value = '0; bus.counter_value = '0;
  endtask

  // Reset asserted off-edge; outputs must clear with no clock edge in between.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check_all_zero(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one prediction per edge while the driver has work in flight.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_reinit",   32'(bus.reinit),        e.reinit);
        check("sb_init",     32'(bus.initial_value), e.init);
        check("sb_incr_v",   32'(bus.incr_valid),    e.iv);
        check("sb_incr",     32'(bus.incr),          e.inc);
        check("sb_decr_v",   32'(bus.decr_valid),    e.dv);
        check("sb_decr",     32'(bus.decr),          e.dec);
        check("sb_pend_up",  32'(bus.pend_up),       e.pu);
        check("sb_pend_dn",  32'(bus.pend_dn),       e.pd);
        check("sb_busy",     32'(bus.busy),          e.busy);
        check("sb_overflow", 32'(bus.overflow),      e.ov);
        check("sb_mirror",   32'(bus.mirror),        e.mirror);
        check("sb_mismatch", 32'(bus.mismatch),      e.mis);
      end
    end
  end

  initial begin
    int cv_mode;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Load 5: reinit for one cycle, then the mirror holds 5.
    cycle(1'b0, 0, 1'b0, 0, 1'b1, 5, -1);
    after_edge();
    check("load_reinit", 32'(bus.reinit), 1);
    check("load_init",   32'(bus.initial_value), 5);
    idle();
    after_edge();
    check("load_reinit_drop", 32'(bus.reinit), 0);
    check("load_mirror",      32'(bus.mirror), CHECK_EN ? 5 : 0);

    // Up and down in the same cycle issue side by side.
    cycle(1'b1, 2, 1'b1, 1, 1'b0, 0, -1);
    idle();
    after_edge();
    check("both_incr", 32'(bus.incr), 2);
    check("both_decr", 32'(bus.decr), 1);
    idle();
    after_edge();
    check("both_mirror", 32'(bus.mirror), CHECK_EN ? 6 : 0);

    // Single up of 7 drains as 3, 3, 1.
    do_reset("rst_a");
    cycle(1'b1, 7, 1'b0, 0, 1'b0, 0, -1);
    after_edge();
    check("up7_pend0", 32'(bus.pend_up), 7);
    idle(); after_edge();
    check("up7_incr1", 32'(bus.incr), 3);
    check("up7_pend1", 32'(bus.pend_up), 4);
    idle(); after_edge();
    check("up7_incr2", 32'(bus.incr), 3);
    check("up7_pend2", 32'(bus.pend_up), 1);
    idle(); after_edge();
    check("up7_incr3", 32'(bus.incr), 1);
    check("up7_pend3", 32'(bus.pend_up), 0);
    idle(); after_edge();
    check("up7_busy_end", 32'(bus.busy), 0);

    // Saturation at 63 with sticky overflow.
    do_reset("rst_b");
    cycle(1'b1, 15, 1'b0, 0, 1'b0, 0, -1); after_edge(); check("sat_p1", 32'(bus.pend_up), 15);
    cycle(1'b1, 15, 1'b0, 0, 1'b0, 0, -1); after_edge(); check("sat_p2", 32'(bus.pend_up), 27);
    cycle(1'b1, 15, 1'b0, 0, 1'b0, 0, -1); after_edge(); check("sat_p3", 32'(bus.pend_up), 39);
    cycle(1'b1, 15, 1'b0, 0, 1'b0, 0, -1); after_edge(); check("sat_p4", 32'(bus.pend_up), 51);
    cycle(1'b1, 15, 1'b0, 0, 1'b0, 0, -1); after_edge(); check("sat_p5", 32'(bus.pend_up), 63);
    check("sat_ovf5", 32'(bus.overflow), 0);
    cycle(1'b1, 15, 1'b0, 0, 1'b0, 0, -1); after_edge(); check("sat_p6", 32'(bus.pend_up), 63);
    check("sat_ovf6", 32'(bus.overflow), 1);
    repeat (4) idle();
    after_edge();
    check("sat_ovf_sticky", 32'(bus.overflow), 1);

    // Mismatch after load 5 with the counter reporting 6.
    do_reset("rst_c");
    cycle(1'b0, 0, 1'b0, 0, 1'b1, 5, -1);
    idle();
    cycle(1'b0, 0, 1'b0, 0, 1'b0, 0, 6);
    after_edge();
    check("mis_set", 32'(bus.mismatch), CHECK_EN ? 1 : 0);
    repeat (3) idle();
    after_edge();
    check("mis_sticky", 32'(bus.mismatch), CHECK_EN ? 1 : 0);

    // Reset while 20 increments are pending.
    do_reset("rst_d");
    cycle(1'b1, 15, 1'b0, 0, 1'b0, 0, -1);
    cycle(1'b1, 8, 1'b0, 0, 1'b0, 0, -1);
    after_edge();
    check("pend20", 32'(bus.pend_up), 20);
    do_reset("rst_mid");

    // Random traffic with occasional loads, counter corruption and one mid-run reset.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset("rst_rand");
      cv_mode = ($urandom_range(0, 59) == 0) ? -2 : -1;
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)), cv_mode);
    end

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
